// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared constants, port-select type and saturating-add helper for the
// dual-port RAM arbiter slice.
package dpram_arb_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_AW   = 6;
  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Add 0..2 to a statistics counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dual_port_ram_arbiter_if.sv
// Requester-side bus of the arbiter: packed per-slot request fields,
// grant pulses and registered read responses.
interface dual_port_ram_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*DW-1:0] rsp_data;

  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rsp_valid, rsp_data
  );

endinterface

// File: rtl/dual_port_ram_arbiter_rr_first_finder.sv
// Round-robin search: first set bit of mask scanning start, start+1, ...
// modulo NREQ. Purely combinational.
module rr_first_finder #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         mask,
  input  logic [$clog2(NREQ)-1:0] start,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  // Walk the rotated scan order and latch the first hit.
  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(start) + k) % NREQ;
      if (!found && mask[j[IW-1:0]]) begin
        found = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Two-grant round-robin arbiter in front of a 64x8 write-first true
// dual-port RAM. Optional statistics counters: define DPRAM_ARB_STATS_EN.
module dual_port_ram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_port_ram_arbiter_if.slave  bus,
  output logic                    ram_we_a,
  output logic                    ram_we_b,
  output logic [AW-1:0]           ram_addr_a,
  output logic [AW-1:0]           ram_addr_b,
  output logic [DW-1:0]           ram_data_a,
  output logic [DW-1:0]           ram_data_b,
  input  logic [DW-1:0]           ram_q_a,
  input  logic [DW-1:0]           ram_q_b
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]        grant_cnt,
  output logic [CNT_W-1:0]        conflict_cnt
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0]      ptr;
  logic               found_a, found_b;
  logic [IW-1:0]      sel_a, sel_b;
  logic [NREQ-1:0]    mask_b;
  logic               we_sa, we_sb;
  logic [AW-1:0]      addr_sa, addr_sb;
  logic [DW-1:0]      wd_sa, wd_sb;
  logic               conflict, grant_a, grant_b;
  logic [IW-1:0]      last_idx, next_ptr;
  logic [NREQ-1:0]    rsp_valid_q;
  port_sel_e          rsp_port [NREQ];
  logic [NREQ*DW-1:0] q_route, data_q;

  rr_first_finder #(.NREQ(NREQ)) u_find_a (
    .mask (bus.req),
    .start(ptr),
    .found(found_a),
    .idx  (sel_a)
  );

  rr_first_finder #(.NREQ(NREQ)) u_find_b (
    .mask (mask_b),
    .start(ptr),
    .found(found_b),
    .idx  (sel_b)
  );

  // Select the two candidates' fields and apply the same-address write rule.
  always_comb begin
    mask_b   = bus.req & ~({{(NREQ-1){1'b0}}, found_a} << sel_a);
    we_sa    = bus.req_we[sel_a];
    we_sb    = bus.req_we[sel_b];
    addr_sa  = bus.req_addr[32'(sel_a)*AW +: AW];
    addr_sb  = bus.req_addr[32'(sel_b)*AW +: AW];
    wd_sa    = bus.req_wdata[32'(sel_a)*DW +: DW];
    wd_sb    = bus.req_wdata[32'(sel_b)*DW +: DW];
    conflict = found_a && found_b && (addr_sa == addr_sb) && (we_sa || we_sb);
    grant_a  = rst_n && found_a;
    grant_b  = rst_n && found_b && !conflict;
    last_idx = grant_b ? sel_b : sel_a;
    next_ptr = (last_idx == IW'(NREQ-1)) ? '0 : last_idx + 1'b1;
  end

  // Drive grants and RAM pins; an ungranted port is held fully idle.
  always_comb begin
    bus.gnt    = '0;
    ram_we_a   = 1'b0;
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_b   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    if (grant_a) begin
      bus.gnt[sel_a] = 1'b1;
      ram_we_a       = we_sa;
      ram_addr_a     = addr_sa;
      ram_data_a     = wd_sa;
    end
    if (grant_b) begin
      bus.gnt[sel_b] = 1'b1;
      ram_we_b       = we_sb;
      ram_addr_b     = addr_sb;
      ram_data_b     = wd_sb;
    end
  end

  // Rotate the pointer and record which port each launched read used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      rsp_valid_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) rsp_port[i] <= PORT_A;
    end else begin
      if (grant_a) ptr <= next_ptr;
      rsp_valid_q <= '0;
      if (grant_a && !we_sa) begin
        rsp_valid_q[sel_a] <= 1'b1;
        rsp_port[sel_a]    <= PORT_A;
      end
      if (grant_b && !we_sb) begin
        rsp_valid_q[sel_b] <= 1'b1;
        rsp_port[sel_b]    <= PORT_B;
      end
    end
  end

  // The RAM q is already registered, so the response cycle shows it directly;
  // data_q captures it at the end of that cycle to hold the value afterwards.
  always_comb begin
    q_route      = '0;
    bus.rsp_data = data_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      q_route[i*DW +: DW] = (rsp_port[i] == PORT_B) ? ram_q_b : ram_q_a;
      if (rsp_valid_q[i]) bus.rsp_data[i*DW +: DW] = q_route[i*DW +: DW];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;

  // Hold last delivered read data per slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (rsp_valid_q[i]) data_q[i*DW +: DW] <= q_route[i*DW +: DW];
      end
    end
  end

`ifdef DPRAM_ARB_STATS_EN
  logic [1:0] n_gnt;
  assign n_gnt = {1'b0, grant_a} + {1'b0, grant_b};

  // Saturating grant and conflict statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      grant_cnt <= sat_add(grant_cnt, n_gnt);
      if (conflict) conflict_cnt <= sat_add(conflict_cnt, 2'd1);
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a behavioural write-first
// RAM and a response scoreboard. Build with DPRAM_ARB_STATS_EN to also
// check the statistics counters.
module tb_dual_port_ram_arbiter;
  import dpram_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  logic          ram_we_a, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
`ifdef DPRAM_ARB_STATS_EN
  logic [15:0]   grant_cnt, conflict_cnt;
`endif

  dual_port_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ram_we_a    (ram_we_a),
    .ram_we_b    (ram_we_b),
    .ram_addr_a  (ram_addr_a),
    .ram_addr_b  (ram_addr_b),
    .ram_data_a  (ram_data_a),
    .ram_data_b  (ram_data_b),
    .ram_q_a     (ram_q_a),
    .ram_q_b     (ram_q_b)
`ifdef DPRAM_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    int          slot;
    logic [7:0]  data;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 64x8 write-first true dual-port RAM; mem[a] = 8'h40 + a.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int a = 0; a < 64; a++) mem[a] <= 8'h40 + 8'(a);
      ram_q_a <= '0;
      ram_q_b <= '0;
    end else begin
      if (ram_we_a) begin
        mem[ram_addr_a] <= ram_data_a;
        ram_q_a <= ram_data_a;
      end else ram_q_a <= mem[ram_addr_a];
      if (ram_we_b) begin
        mem[ram_addr_b] <= ram_data_b;
        ram_q_b <= ram_data_b;
      end else ram_q_b <= mem[ram_addr_b];
    end
  end

  // Protocol check: a pending ungranted request must not be withdrawn.
  logic [NREQ-1:0] must_hold = '0;
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      assert (!(must_hold[i +: 1] == 1'b1 && bus.req[i +: 1] == 1'b0))
      else begin
        n_err++;
        $display("FAIL req_drop: slot %0d withdrew req before gnt (cycle %0d)", i, cyc);
      end
    end
    must_hold <= rst_n ? (bus.req & ~bus.gnt) : '0;
  end

  // Response monitor: compare every slot that is expected or presents valid.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      logic          ev;
      logic [DW-1:0] ed;
      ev = 1'b0;
      ed = '0;
      foreach (sbq[k]) begin
        if (sbq[k].cyc == cyc && sbq[k].slot == i) begin
          ev = 1'b1;
          ed = sbq[k].data;
        end
      end
      if (ev || bus.rsp_valid[i +: 1] == 1'b1) begin
        n_cmp++;
        if (bus.rsp_valid[i +: 1] !== ev || bus.rsp_data[i*DW +: DW] !== ed) begin
          n_err++;
          $display("FAIL rsp slot %0d: got valid=%0b data=%02h, expected valid=%0b data=%02h (cycle %0d)",
                   i, bus.rsp_valid[i +: 1], bus.rsp_data[i*DW +: DW], ev, ed, cyc);
        end
      end
    end
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc <= cyc) sbq.delete(k);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ports(input string n, input logic [NREQ-1:0] g,
                           input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                           input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    chk({n, ".gnt"},    32'(bus.gnt),    32'(g));
    chk({n, ".we_a"},   32'(ram_we_a),   32'(wa));
    chk({n, ".addr_a"}, 32'(ram_addr_a), 32'(aa));
    chk({n, ".data_a"}, 32'(ram_data_a), 32'(da));
    chk({n, ".we_b"},   32'(ram_we_b),   32'(wb));
    chk({n, ".addr_b"}, 32'(ram_addr_b), 32'(ab));
    chk({n, ".data_b"}, 32'(ram_data_b), 32'(db));
  endtask

  task automatic set_slot(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[i +: 1]         = 1'b1;
    bus.req_we[i +: 1]      = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr_slot(input int i);
    bus.req[i +: 1] = 1'b0;
  endtask

  task automatic expect_rsp(input int slot, input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.slot = slot;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset with a request present: grants and write enables stay low.
    next_cycle();
    set_slot(0, 1'b1, 6'd5, 8'hA5);
    sample();
    chk("rst.gnt",  32'(bus.gnt), 32'h0);
    chk("rst.we_a", 32'(ram_we_a), 32'h0);
    chk("rst.we_b", 32'(ram_we_b), 32'h0);

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 0) begin
        rst_n   = 1'b1;
        bus.req = '0;
      end
      sample();
      chk("idle.gnt", 32'(bus.gnt), 32'h0);
      chk("idle.we",  32'({ram_we_a, ram_we_b}), 32'h0);
      chk("idle.rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("idle.ptr", 32'(dut.ptr), 32'h0);
      if (c == 0) chk("idle.rsp_data", bus.rsp_data, 32'h0);
    end

    // Write then read back through a different requester.
    next_cycle();
    set_slot(0, 1'b1, 6'd5, 8'hA5);
    sample();
    chk_ports("wr0", 4'b0001, 1'b1, 6'd5, 8'hA5, 1'b0, 6'd0, 8'h00);

    next_cycle();
    clr_slot(0);
    set_slot(2, 1'b0, 6'd5, 8'h00);
    sample();
    chk_ports("rd2", 4'b0100, 1'b0, 6'd5, 8'h00, 1'b0, 6'd0, 8'h00);
    expect_rsp(2, 8'hA5);

    next_cycle();
    clr_slot(2);
    sample();
    chk("gap.gnt", 32'(bus.gnt), 32'h0);

    // Lone requester goes to port A; slot 2 data holds after valid drops.
    next_cycle();
    set_slot(3, 1'b1, 6'd7, 8'h3C);
    sample();
    chk_ports("wr3", 4'b1000, 1'b1, 6'd7, 8'h3C, 1'b0, 6'd0, 8'h00);
    chk("hold.valid2", 32'(bus.rsp_valid[2]), 32'h0);
    chk("hold.data2",  32'(bus.rsp_data[2*DW +: DW]), 32'hA5);

    // All four read distinct addresses, held four cycles.
    next_cycle();
    set_slot(0, 1'b0, 6'd10, 8'h00);
    set_slot(1, 1'b0, 6'd11, 8'h00);
    set_slot(2, 1'b0, 6'd12, 8'h00);
    set_slot(3, 1'b0, 6'd13, 8'h00);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      sample();
      if (c % 2 == 0) begin
        chk_ports("rr01", 4'b0011, 1'b0, 6'd10, 8'h00, 1'b0, 6'd11, 8'h00);
        expect_rsp(0, 8'h4A);
        expect_rsp(1, 8'h4B);
      end else begin
        chk_ports("rr23", 4'b1100, 1'b0, 6'd12, 8'h00, 1'b0, 6'd13, 8'h00);
        expect_rsp(2, 8'h4C);
        expect_rsp(3, 8'h4D);
      end
    end

    // Slots 0 and 1 are still pending; serve them, then slot 0 alone.
    next_cycle();
    clr_slot(2);
    clr_slot(3);
    sample();
    chk_ports("rr01b", 4'b0011, 1'b0, 6'd10, 8'h00, 1'b0, 6'd11, 8'h00);
    expect_rsp(0, 8'h4A);
    expect_rsp(1, 8'h4B);

    next_cycle();
    clr_slot(1);
    sample();
    chk_ports("rd0", 4'b0001, 1'b0, 6'd10, 8'h00, 1'b0, 6'd0, 8'h00);
    expect_rsp(0, 8'h4A);

    // Same-address write collision with ptr=1.
    next_cycle();
    clr_slot(0);
    set_slot(1, 1'b1, 6'd9, 8'h11);
    set_slot(2, 1'b1, 6'd9, 8'h22);
    sample();
    chk("conf.ptr", 32'(dut.ptr), 32'h1);
    chk_ports("conf1", 4'b0010, 1'b1, 6'd9, 8'h11, 1'b0, 6'd0, 8'h00);

    next_cycle();
    clr_slot(1);
    sample();
    chk_ports("conf2", 4'b0100, 1'b1, 6'd9, 8'h22, 1'b0, 6'd0, 8'h00);

    next_cycle();
    clr_slot(2);
    set_slot(3, 1'b0, 6'd9, 8'h00);
    sample();
    chk_ports("rd9", 4'b1000, 1'b0, 6'd9, 8'h00, 1'b0, 6'd0, 8'h00);
    expect_rsp(3, 8'h22);

    next_cycle();
    clr_slot(3);
    sample();
    chk("post.gnt", 32'(bus.gnt), 32'h0);
`ifdef DPRAM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'd1);
    chk("grant_cnt",    32'(grant_cnt),    32'd17);
`endif

    // Two reads of the same address are both granted.
    next_cycle();
    set_slot(0, 1'b0, 6'd7, 8'h00);
    set_slot(3, 1'b0, 6'd7, 8'h00);
    sample();
    chk_ports("dup7", 4'b1001, 1'b0, 6'd7, 8'h00, 1'b0, 6'd7, 8'h00);
    expect_rsp(0, 8'h3C);
    expect_rsp(3, 8'h3C);

    // Read issued, then reset sampled at the closing edge: no response.
    next_cycle();
    clr_slot(0);
    clr_slot(3);
    set_slot(1, 1'b0, 6'd11, 8'h00);
    sample();
    chk("inflight.gnt", 32'(bus.gnt), 32'b0010);
    #1 rst_n = 1'b0;

    next_cycle();
    sample();
    chk("rst2.gnt",       32'(bus.gnt), 32'h0);
    chk("rst2.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst2.ptr",       32'(dut.ptr), 32'h0);
    chk("rst2.rsp_data",  bus.rsp_data, 32'h0);

    next_cycle();
    rst_n = 1'b1;
    sample();
    chk_ports("rerd", 4'b0010, 1'b0, 6'd11, 8'h00, 1'b0, 6'd0, 8'h00);
    expect_rsp(1, 8'h4B);

    next_cycle();
    clr_slot(1);
    sample();
    chk("end.gnt", 32'(bus.gnt), 32'h0);

    next_cycle();
    sample();
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_arbiter.md
Name: dual_port_ram_arbiter

Overview:
- Shares the team's 64x8 write-first true dual-port RAM among NREQ requesters.
- Each cycle, grants up to two requests: one on RAM port A, one on port B, round-robin.
- Routes registered read data back to the requester that issued the read.
- Blocks same-address write collisions.
- Sits between requester logic and the RAM instance. It drives the RAM's addr/data/we pins and samples q_a/q_b.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 8, RAM data width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  request per requester; held with fields stable until granted
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses; slot i = bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- gnt  out  NREQ  combinational grant pulse; request accepted this cycle
- rsp_valid  out  NREQ  registered; read data valid for slot i
- rsp_data  out  NREQ*DW  registered read data per slot
- ram_we_a, ram_we_b  out  1  RAM write enables
- ram_addr_a, ram_addr_b  out  AW  RAM addresses
- ram_data_a, ram_data_b  out  DW  RAM write data
- ram_q_a, ram_q_b  in  DW  RAM registered outputs

Behaviour:
- Reset (rst_n low at posedge):
  - ptr=0, rsp_valid=0, rsp_data=0, pending-port flags cleared.
  - While rst_n is low, gnt=0 and ram_we_a/b=0 combinationally.
  - Reads in flight when reset asserts are dropped; no rsp_valid is issued for them.
- Arbitration, combinational in cycle T:
  - selA = first i with req[i], scanning ptr, ptr+1, ... mod NREQ.
  - selB = next set req after selA in the same scan.
  - gnt[selA] and gnt[selB] assert. Port A gets selA's we/addr/wdata; port B gets selB's.
  - Ungranted port: we=0, addr=0, data=0.
- Conflict rule:
  - Applies when selA and selB have equal addr and at least one of them writes.
  - Only selA is granted; selB is not granted and stays pending.
  - Two reads to the same address are both granted.
- Pointer update at posedge:
  - ptr = (last granted index + 1) mod NREQ.
  - ptr holds when nothing is granted.
- Fairness: any held request is granted within NREQ cycles.
- Read latency:
  - A read granted in T gives rsp_valid[i]=1 for exactly cycle T+1.
  - rsp_data slot i is loaded from the q of the port used. A 1-bit per-slot register records A/B.
  - rsp_data holds its value after rsp_valid drops.
- Writes: no response. They are visible to reads granted from T+1 onward.
- Same requester re-requesting in T+1:
  - Allowed. Its rsp_valid from the previous read and its new gnt may both be high in T+1.
- Requester protocol:
  - Dropping req before gnt is illegal and the behaviour is undefined.
  - A bench assertion flags it.
- Single requester active: always routed to port A. Port B stays idle.

Optional Feature:
- Macro: DPRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt (16) and conflict_cnt (16).
  - Both are saturating counters, reset to 0.
  - grant_cnt increments by the number of grants (0/1/2) each cycle.
  - conflict_cnt increments by 1 on each cycle the conflict rule suppressed selB.
  - Both stick at 16'hFFFF.
- When undefined: the ports and counters are absent. Arbitration behaviour is identical.

Decomposition:
- Package dpram_arb_pkg:
  - Default AW/DW/NREQ constants.
  - port_sel_e enum (PORT_A, PORT_B).
  - Counter width constant (16).
- One sub-module, rr_first_finder:
  - Parameterised NREQ, purely combinational.
  - Given req mask and start pointer, returns found flag and index.
  - Instantiated twice: second instance uses the mask with selA cleared.

Test Plan:
- Reset, then req=0: gnt=0, ram_we_a/b=0, rsp_valid=0 for 5 cycles. ptr stays 0.
- Requester 0 writes addr 5 = 8'hA5. Next cycle requester 2 reads addr 5 -> gnt[2], then rsp_valid[2]=1 one cycle later with rsp_data slot 2 = 8'hA5.
- req=4'b1111, all reads to distinct addresses, held 4 cycles:
  - Grants are {0,1}, {2,3}, {0,1}, {2,3}.
  - Each rsp_valid is 1 cycle after its gnt.
- Req 1 writes addr 9 and req 2 writes addr 9 with ptr=1:
  - Cycle 1: gnt=4'b0010 only, port B idle.
  - Cycle 2: gnt[2], port A, write.
  - Final mem[9] = req 2 data. conflict_cnt=1 with DPRAM_ARB_STATS_EN.
- Req 0 and req 3 both read addr 7 (holding 8'h3C) in the same cycle: both granted; both rsp_data = 8'h3C next cycle.
- Read granted, then rst_n=0 on the following posedge: rsp_valid stays 0, ptr=0. Re-issued read after reset completes normally.
